// File: rtl/force_ramp_controller_pkg.sv
// Shared encodings and rotor-speed limits for the force ramp sequencer.
package force_ramp_controller_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RAMP  = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;
  localparam state_t ST_FAULT = 2'd3;

  // Period reported for a stopped rotor, and the 2 mph / 10 mph step periods.
  localparam logic [19:0] PERIOD_STOP  = 20'h7ffff;
  localparam logic [19:0] PERIOD_2MPH  = 20'h01496;
  localparam logic [19:0] PERIOD_10MPH = 20'h0041E;

endpackage

// File: rtl/force_ramp_controller_tach_period_meter.sv
// Tach period meter: 2-FF sync, rising-edge detect, saturating clock counter.
// Period is registered 3 clocks after tach rises; no backpressure (free-running).
module tach_period_meter #(
  parameter int unsigned PERIOD_W   = 32,
  parameter int unsigned MAX_PERIOD = 32'h7ffff,
  parameter int unsigned MIN_PERIOD = 32'h41e
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tach,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_overspeed
);

  localparam logic [PERIOD_W-1:0] P_MAX = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(MIN_PERIOD);

  logic                r_tach_s1;
  logic                r_tach_s2;
  logic                r_tach_d;
  logic                r_armed;
  logic                r_meas;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic                w_edge;

  assign w_edge = r_tach_s2 & ~r_tach_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tach_s1 <= 1'b0;
      r_tach_s2 <= 1'b0;
      r_tach_d  <= 1'b0;
    end else begin
      r_tach_s1 <= i_tach;
      r_tach_s2 <= r_tach_s1;
      r_tach_d  <= r_tach_s2;
    end
  end

  // The first edge after reset only opens the window: its count is reported but not trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_period <= P_MAX;
      r_armed  <= 1'b0;
      r_meas   <= 1'b0;
    end else if (w_edge) begin
      r_period <= r_cnt;
      r_cnt    <= PERIOD_W'(1);
      r_armed  <= 1'b1;
      r_meas   <= r_armed;
    end else if (r_cnt == P_MAX) begin
      r_period <= P_MAX;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_period    = r_period;
  assign o_overspeed = r_meas && (r_period < P_MIN);

endmodule

// File: rtl/force_ramp_controller.sv
// Force sequencer: ramps force_n toward accepted targets, one step per RAMP_DIV clocks.
// cmd_ready is combinational and drops in FAULT or during abort; overspeed zeroes force next clock.
module force_ramp_controller
  import force_ramp_controller_pkg::*;
#(
  parameter int unsigned FORCE_W    = 32,
  parameter int unsigned PERIOD_W   = 32,
  parameter int unsigned MAX_PERIOD = 32'(PERIOD_STOP),
  parameter int unsigned MIN_PERIOD = 32'(PERIOD_10MPH),
  parameter int unsigned FORCE_MAX  = 25,
  parameter int unsigned FORCE_STEP = 1,
  parameter int unsigned RAMP_DIV   = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tach,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [FORCE_W-1:0]  i_cmd_force,
  input  logic                i_cmd_abort,
  output logic [FORCE_W-1:0]  o_force_n,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_busy,
  output logic                o_fault,
  output logic [1:0]          o_state
);

  localparam int unsigned          TMR_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(RAMP_DIV - 1);
  localparam logic [FORCE_W-1:0]   F_MAX    = FORCE_W'(FORCE_MAX);
  localparam logic [FORCE_W:0]     F_STEP_W = (FORCE_W + 1)'(FORCE_STEP);

  state_t             r_state;
  logic [FORCE_W-1:0] r_force;
  logic [FORCE_W-1:0] r_target;
  logic [TMR_W-1:0]   r_tmr;

  logic               w_overspeed;
  logic               w_accept;
  logic [FORCE_W-1:0] w_clamped;
  logic [FORCE_W:0]   w_up;
  logic [FORCE_W:0]   w_dn_lim;
  logic [FORCE_W-1:0] w_force_next;
  state_t             w_accept_state;

  tach_period_meter #(
    .PERIOD_W   (PERIOD_W),
    .MAX_PERIOD (MAX_PERIOD),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_meter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tach      (i_tach),
    .o_period    (o_period),
    .o_overspeed (w_overspeed)
  );

  assign o_cmd_ready = (r_state != ST_FAULT) && !i_cmd_abort;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_clamped   = (i_cmd_force > F_MAX) ? F_MAX : i_cmd_force;

  assign w_accept_state = (w_clamped == r_force) ? ((w_clamped == '0) ? ST_IDLE : ST_HOLD)
                                                 : ST_RAMP;

  // One extra bit keeps the step from wrapping at zero or all-ones; result snaps to target.
  assign w_up     = {1'b0, r_force} + F_STEP_W;
  assign w_dn_lim = {1'b0, r_target} + F_STEP_W;

  always_comb begin
    w_force_next = r_target;
    if (r_force < r_target) begin
      if (w_up < {1'b0, r_target}) w_force_next = w_up[FORCE_W-1:0];
    end else if ({1'b0, r_force} >= w_dn_lim) begin
      w_force_next = r_force - FORCE_W'(FORCE_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_force  <= '0;
      r_target <= '0;
      r_tmr    <= '0;
    end else if (w_overspeed) begin
      r_state  <= ST_FAULT;
      r_force  <= '0;
      r_target <= '0;
    end else if (r_state == ST_FAULT) begin
      if (i_cmd_abort) r_state <= ST_IDLE;
    end else if (i_cmd_abort) begin
      r_state  <= ST_IDLE;
      r_force  <= '0;
      r_target <= '0;
    end else if (w_accept) begin
      r_target <= w_clamped;
      r_tmr    <= '0;
      r_state  <= w_accept_state;
    end else if (r_state == ST_RAMP) begin
      if (r_tmr == TMR_LAST) begin
        r_tmr   <= '0;
        r_force <= w_force_next;
        if (w_force_next == r_target) r_state <= (r_target == '0) ? ST_IDLE : ST_HOLD;
      end else begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  assign o_force_n = r_force;
  assign o_state   = r_state;
  assign o_busy    = (r_state == ST_RAMP) || (r_state == ST_HOLD);
  assign o_fault   = (r_state == ST_FAULT);

endmodule

// File: tb/tb_force_ramp_controller.sv
// Scoreboarded bench: a cycle-level reference model pushes expected outputs, a negedge monitor compares.
module tb_force_ramp_controller;

  localparam int unsigned FW   = 32;
  localparam int unsigned PW   = 32;
  localparam int unsigned DIV  = 4;
  localparam int unsigned PMAX = 32'h3fff;
  localparam int unsigned PMIN = 32'h41e;
  localparam int unsigned FMAX = 25;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tach = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [FW-1:0] cmd_force = '0;
  logic          cmd_ready;
  logic          busy;
  logic          fault;
  logic [FW-1:0] force_n;
  logic [PW-1:0] period;
  logic [1:0]    state;

  always #5 clk = ~clk;

  force_ramp_controller #(
    .FORCE_W(FW), .PERIOD_W(PW), .MAX_PERIOD(PMAX), .MIN_PERIOD(PMIN),
    .FORCE_MAX(FMAX), .FORCE_STEP(1), .RAMP_DIV(DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_tach(tach), .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready), .i_cmd_force(cmd_force), .i_cmd_abort(cmd_abort),
    .o_force_n(force_n), .o_period(period), .o_busy(busy), .o_fault(fault), .o_state(state)
  );

  typedef struct {
    logic [31:0] f;
    logic [31:0] p;
    logic [1:0]  st;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: states 0 idle, 1 ramp, 2 hold, 3 fault.
  int unsigned m_n = 0, m_eprev = 1, m_t0 = 0, m_f = 0, m_tgt = 0, m_per = PMAX;
  int          m_st = 0;
  bit          m_seen = 0, m_meas = 0;
  int unsigned edge_q[$];
  int unsigned tach_sp = 0, tach_ph = 0;
  bit          tach_prev = 0;

  task automatic m_reset();
    m_f = 0; m_tgt = 0; m_st = 0; m_per = PMAX;
    m_seen = 0; m_meas = 0;
    edge_q.delete();
    m_eprev = m_n + 1;
  endtask

  task automatic m_clock();
    bit fast;
    m_n++;
    if (!rst_n) begin
      m_reset();
      return;
    end
    fast = m_meas && (m_per < PMIN);
    if (fast) begin
      m_st = 3; m_f = 0; m_tgt = 0;
    end else if (m_st == 3) begin
      if (cmd_abort) m_st = 0;
    end else if (cmd_abort) begin
      m_st = 0; m_f = 0; m_tgt = 0;
    end else if (cmd_valid) begin
      m_tgt = (cmd_force > FMAX) ? FMAX : cmd_force;
      m_t0  = m_n;
      m_st  = (m_tgt == m_f) ? ((m_tgt == 0) ? 0 : 2) : 1;
    end else if (m_st == 1 && ((m_n - m_t0) % DIV) == 0) begin
      if (m_f < m_tgt) m_f++; else m_f--;
      if (m_f == m_tgt) m_st = (m_tgt == 0) ? 0 : 2;
    end
    // Period = clocks between detected edges, capped; the first edge since reset is untrusted.
    if (edge_q.size() > 0 && edge_q[0] == m_n) begin
      void'(edge_q.pop_front());
      m_per   = ((m_n - m_eprev) > PMAX) ? PMAX : (m_n - m_eprev);
      m_meas  = m_seen;
      m_seen  = 1;
      m_eprev = m_n;
    end else if ((m_n - m_eprev) >= PMAX) begin
      m_per = PMAX;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.f   = m_f;
    e.p   = m_per;
    e.st  = 2'(m_st);
    e.rdy = (m_st != 3) && !cmd_abort;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit v, input int unsigned f, input bit a);
    bit t;
    cmd_valid = v; cmd_force = f; cmd_abort = a;
    if (tach_sp == 0) begin
      t = 0; tach_ph = 0;
    end else begin
      t = (tach_ph < tach_sp / 2);
      tach_ph = (tach_ph + 1) % tach_sp;
    end
    tach = t;
    // Synchroniser plus edge register: sampled at the next edge, seen two edges after that.
    if (t && !tach_prev) edge_q.push_back(m_n + 3);
    tach_prev = t;
    push_exp();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle(input int unsigned k);
    repeat (k) cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; cmd_valid = 0; cmd_force = 0; cmd_abort = 0;
    tach = 0; tach_prev = 0; tach_ph = 0;
    m_reset();
    repeat (3) begin
      push_exp();
      @(posedge clk);
      m_clock();
      #1;
    end
    rst_n = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, m_n, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        chk("force_n", force_n, e.f);
        chk("period", period, e.p);
        chk("state", 32'(state), 32'(e.st));
        chk("busy", 32'(busy), 32'(e.st == 2'd1 || e.st == 2'd2));
        chk("fault", 32'(fault), 32'(e.st == 2'd3));
        chk("cmd_ready", 32'(cmd_ready), 32'(e.rdy));
      end
    end
  end

  initial begin : stimulus
    int unsigned sp_tab [4];
    int unsigned r;
    int unsigned f;
    sp_tab[0] = 0; sp_tab[1] = 1500; sp_tab[2] = 3000; sp_tab[3] = 800;

    @(posedge clk);
    #1;
    do_reset();
    idle(3);

    cyc(1, 10, 0); idle(45);
    cyc(1, 0, 0);  idle(45);

    cyc(1, 40, 0); idle(110);
    cyc(1, 25, 0); idle(10);

    tach_sp = 5270; tach_ph = 0; idle(3 * 5270 + 20);
    tach_sp = 0; idle(PMAX + 20);

    tach_sp = 1000; tach_ph = 0; idle(2600);
    repeat (3) cyc(0, 0, 1);
    tach_sp = 5270; tach_ph = 0; idle(2 * 5270 + 20);
    cyc(0, 0, 1); idle(3);
    tach_sp = 0;

    cyc(1, 20, 0); idle(24);
    cyc(1, 20, 1); idle(3);

    for (int i = 0; i < 4000; i++) begin
      if ((i % 1000) == 0) begin
        tach_sp = sp_tab[$urandom_range(0, 3)];
        tach_ph = 0;
      end
      r = $urandom_range(0, 99);
      f = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, 40);
      cyc(r < 6, f, r >= 98);
    end

    cyc(1, 18, 0); idle(20);
    do_reset();
    idle(10);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
